// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter
// Two-port arbiter/sequencer in front of the 1024x16 data RAM.
// Port A is the CPU load/store path and port B is the loader/debug path.
// Every accepted request becomes exactly one registered RAM access. The
// granted port then receives a one-cycle response pulse that carries the
// read data for loads.
//
// Handshake: x_req_ready is a combinational grant. It is only ever 1 while
// x_req_valid is 1 and the sequencer is in IDLE or RESP. A request is taken
// on the rising edge where x_req_valid && x_req_ready. While valid is high
// and ready is low, the requester must hold addr/we/wdata stable. It may drop
// valid at any time before acceptance. x_rsp_valid is a single-cycle pulse
// with no backpressure.
module ram_access_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 16,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req_valid,
    output logic              a_req_ready,
    input  logic              a_req_we,
    input  logic [ADDR_W-1:0] a_req_addr,
    input  logic [DATA_W-1:0] a_req_wdata,
    output logic              a_rsp_valid,
    output logic [DATA_W-1:0] a_rsp_rdata,
    input  logic              b_req_valid,
    output logic              b_req_ready,
    input  logic              b_req_we,
    input  logic [ADDR_W-1:0] b_req_addr,
    input  logic [DATA_W-1:0] b_req_wdata,
    output logic              b_rsp_valid,
    output logic [DATA_W-1:0] b_rsp_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_write_data,
    output logic              ram_write_enable,
    input  logic [DATA_W-1:0] ram_read_data,
    output logic              busy
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    logic [1:0]        state;
    logic [1:0]        state_next;
    logic              last_grant;   // 0 = A granted last, 1 = B granted last
    logic              cur_port;     // port owning the access in flight
    logic              arb_en;
    logic              a_win;
    logic              b_win;
    logic              accept;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // Arbitration: only in IDLE/RESP; A wins ties under fixed priority or when B went last
    always_comb begin
        arb_en = (state == IDLE) || (state == RESP);
        a_win  = arb_en && a_req_valid &&
                 (!b_req_valid || (FIXED_PRIO != 0) || last_grant);
        b_win  = arb_en && b_req_valid &&
                 !(a_req_valid && ((FIXED_PRIO != 0) || last_grant));
        accept = a_win || b_win;
    end

    assign a_req_ready = a_win;
    assign b_req_ready = b_win;

    // Request fields of the winning port
    always_comb begin
        sel_we    = b_win ? b_req_we    : a_req_we;
        sel_addr  = b_win ? b_req_addr  : a_req_addr;
        sel_wdata = b_win ? b_req_wdata : a_req_wdata;
    end

    // Next state: ACCESS and RESP each last one cycle; RESP may chain into ACCESS
    always_comb begin
        state_next = IDLE;
        case (state)
            IDLE:    state_next = accept ? ACCESS : IDLE;
            ACCESS:  state_next = RESP;
            RESP:    state_next = accept ? ACCESS : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Sequencer registers: RAM command, response pulses, grant history
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= IDLE;
            busy             <= 1'b0;
            last_grant       <= 1'b1;
            cur_port         <= 1'b0;
            ram_addr         <= '0;
            ram_write_data   <= '0;
            ram_write_enable <= 1'b0;
            a_rsp_valid      <= 1'b0;
            a_rsp_rdata      <= '0;
            b_rsp_valid      <= 1'b0;
            b_rsp_rdata      <= '0;
        end else begin
            state <= state_next;
            busy  <= (state_next != IDLE);
            case (state)
                IDLE, RESP: begin
                    a_rsp_valid      <= 1'b0;
                    b_rsp_valid      <= 1'b0;
                    ram_write_enable <= 1'b0;
                    if (accept) begin
                        cur_port         <= b_win;
                        last_grant       <= b_win;
                        ram_addr         <= sel_addr;
                        ram_write_enable <= sel_we;
                        // Write data only moves on stores so loads leave the bus quiet
                        if (sel_we) begin
                            ram_write_data <= sel_wdata;
                        end
                    end
                end
                ACCESS: begin
                    // ram_write_enable still holds the we of this access here
                    ram_write_enable <= 1'b0;
                    if (cur_port) begin
                        b_rsp_valid <= 1'b1;
                        if (!ram_write_enable) begin
                            b_rsp_rdata <= ram_read_data;
                        end
                    end else begin
                        a_rsp_valid <= 1'b1;
                        if (!ram_write_enable) begin
                            a_rsp_rdata <= ram_read_data;
                        end
                    end
                end
                default: begin
                    ram_write_enable <= 1'b0;
                    a_rsp_valid      <= 1'b0;
                    b_rsp_valid      <= 1'b0;
                end
            endcase
        end
    end

endmodule
